// File: rtl/btb_assoc_mp_pkg.sv
// btb_assoc_mp_pkg: shared BTB entry types, geometry defaults and flush FSM states
package btb_assoc_mp_pkg;

    localparam int BTB_NUM_SETS = 16;
    localparam int BTB_NUM_WAYS = 4;

    // Field widths cover the widest legal geometry (at least 2 sets, up to 256 ways).
    // Tag and age bits above the configured widths are always written as 0.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [7:0]  age;
    } BTB_ENTRY;

    typedef BTB_ENTRY [BTB_NUM_WAYS-1:0] BTB_SET;

    typedef enum logic {
        IDLE,
        WALK
    } flush_state_t;

endpackage

// File: rtl/btb_set_update.sv
// btb_set_update: next state of one BTB set after a single install or invalidate
//   set_in     : current set contents (result of any earlier ports this cycle)
//   en         : apply the request
//   invalidate : 1 = remove a matching entry, 0 = install/update
//   tag/target : request tag and branch target
//   set_out    : set contents after the request
module btb_set_update
    import btb_assoc_mp_pkg::*;
#(
    parameter int NUM_WAYS = BTB_NUM_WAYS
) (
    input  BTB_ENTRY [NUM_WAYS-1:0] set_in,
    input  logic                    en,
    input  logic                    invalidate,
    input  logic [29:0]             tag,
    input  logic [31:0]             target,
    output BTB_ENTRY [NUM_WAYS-1:0] set_out
);
    localparam int WB = $clog2(NUM_WAYS);

    logic          hit;
    logic          has_free;
    logic [WB-1:0] hit_way;
    logic [WB-1:0] free_way;
    logic [WB-1:0] lru_way;
    logic [WB-1:0] sel;

    always_comb begin
        hit      = 1'b0;
        has_free = 1'b0;
        hit_way  = '0;
        free_way = '0;
        lru_way  = '0;
        // Descending scan so the lowest-index candidate wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (set_in[w].valid && set_in[w].tag == tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!set_in[w].valid) begin
                has_free = 1'b1;
                free_way = WB'(w);
            end
            if (set_in[w].age == 8'd0)
                lru_way = WB'(w);
        end
        sel     = hit ? hit_way : (has_free ? free_way : lru_way);
        set_out = set_in;
        if (en && invalidate && hit)
            set_out[hit_way].valid = 1'b0;
        else if (en && !invalidate) begin
            // Touch: ages above the touched way shift down, keeping a permutation.
            for (int w = 0; w < NUM_WAYS; w++)
                if (set_in[w].age > set_in[sel].age)
                    set_out[w].age = set_in[w].age - 8'd1;
            set_out[sel] = '{valid: 1'b1, tag: tag, target: target, age: 8'(NUM_WAYS - 1)};
        end
    end

endmodule

// File: rtl/btb_assoc_mp.sv
// btb_assoc_mp: set-associative BTB, N_RD registered lookup lanes, N_WR ordered resolve ports, walking flush
//   clock, reset       : clock, synchronous active-high reset
//   rd_valid/rd_pc     : lookup request per lane
//   rd_hit/rd_target   : lookup result one cycle later (target 0 on miss)
//   wr_valid/wr_invalidate/wr_pc/wr_target : resolve writes, port 0 oldest
//   flush_req          : start invalidating every set, one set per cycle
//   flush_busy         : high while the flush walk runs
module btb_assoc_mp
    import btb_assoc_mp_pkg::*;
#(
    parameter int N_RD     = 3,
    parameter int N_WR     = 2,
    parameter int NUM_SETS = BTB_NUM_SETS,
    parameter int NUM_WAYS = BTB_NUM_WAYS,
    parameter int IDX_BITS = $clog2(NUM_SETS),
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_RD-1:0]        rd_valid,
    input  logic [N_RD-1:0][31:0]  rd_pc,
    output logic [N_RD-1:0]        rd_hit,
    output logic [N_RD-1:0][31:0]  rd_target,
    input  logic [N_WR-1:0]        wr_valid,
    input  logic [N_WR-1:0]        wr_invalidate,
    input  logic [N_WR-1:0][31:0]  wr_pc,
    input  logic [N_WR-1:0][31:0]  wr_target,
    input  logic                   flush_req,
    output logic                   flush_busy
);
    typedef BTB_ENTRY [NUM_WAYS-1:0] set_t;

    set_t                          arr     [NUM_SETS];
    set_t                          arr_n   [NUM_SETS];
    set_t                          stg_in  [N_WR];
    set_t                          stg_out [N_WR];
    flush_state_t                  state;
    flush_state_t                  state_n;
    logic [IDX_BITS-1:0]           cnt;
    logic [IDX_BITS-1:0]           cnt_n;
    logic                          busy;
    logic [N_WR-1:0]               wr_act;
    logic [N_WR-1:0][IDX_BITS-1:0] wr_idx;
    logic [N_WR-1:0][29:0]         wr_tag;
    logic [N_RD-1:0]               hit_n;
    logic [N_RD-1:0][31:0]         tgt_n;

    function automatic logic [29:0] pc_tag(input logic [31:0] pc);
        return 30'(pc[31 -: TAG_BITS]);
    endfunction

    assign busy       = state == WALK;
    assign flush_busy = busy;

    always_comb begin
        for (int p = 0; p < N_WR; p++) begin
            wr_act[p] = wr_valid[p] && !busy;
            wr_idx[p] = wr_pc[p][2 +: IDX_BITS];
            wr_tag[p] = pc_tag(wr_pc[p]);
        end
    end

    // Each port starts from the stored set unless an earlier port touched the
    // same set this cycle, in which case it chains off the latest such port.
    for (genvar p = 0; p < N_WR; p++) begin : g_wr
        always_comb begin
            stg_in[p] = arr[wr_idx[p]];
            for (int q = 0; q < p; q++)
                if (wr_act[q] && wr_idx[q] == wr_idx[p])
                    stg_in[p] = stg_out[q];
        end
        btb_set_update #(.NUM_WAYS(NUM_WAYS)) u_upd (
            .set_in     (stg_in[p]),
            .en         (wr_act[p]),
            .invalidate (wr_invalidate[p]),
            .tag        (wr_tag[p]),
            .target     (wr_target[p]),
            .set_out    (stg_out[p])
        );
    end

    always_comb begin
        arr_n = arr;
        for (int p = 0; p < N_WR; p++)
            if (wr_act[p])
                arr_n[wr_idx[p]] = stg_out[p];
        if (busy)
            for (int w = 0; w < NUM_WAYS; w++) begin
                arr_n[cnt][w].valid = 1'b0;
                arr_n[cnt][w].age   = 8'(w);
            end
    end

    // Lookups see the array as held this cycle; writes land only at the edge.
    always_comb begin
        hit_n = '0;
        tgt_n = '0;
        for (int i = 0; i < N_RD; i++)
            for (int w = 0; w < NUM_WAYS; w++)
                if (rd_valid[i] && !busy && arr[rd_pc[i][2 +: IDX_BITS]][w].valid &&
                    arr[rd_pc[i][2 +: IDX_BITS]][w].tag == pc_tag(rd_pc[i])) begin
                    hit_n[i] = 1'b1;
                    tgt_n[i] = arr[rd_pc[i][2 +: IDX_BITS]][w].target;
                end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            state_n = flush_req ? WALK : IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n   = cnt + 1'b1;
            state_n = (cnt == IDX_BITS'(NUM_SETS - 1)) ? IDLE : WALK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_hit    <= '0;
            rd_target <= '0;
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    arr[s][w] <= '{valid: 1'b0, tag: '0, target: '0, age: 8'(w)};
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_hit    <= hit_n;
            rd_target <= tgt_n;
            arr       <= arr_n;
        end
    end

endmodule
